// File: rtl/sbox_cfg_ctrl.sv
// sbox_cfg_ctrl: serialises one 16-nibble S-box row into 16 edit-bus writes, stalling on DES activity.
// Optional permanent configuration lock enabled by defining SBOX_CFG_LOCK_EN.
module sbox_cfg_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_row_valid,
  output logic        o_row_ready,
  input  logic [63:0] i_row_data,
  input  logic [2:0]  i_sbox_sel,
  input  logic [1:0]  i_row_sel,
  input  logic        i_des_busy,
  input  logic        i_lock,
  output logic        edit_sbox,
  output logic [3:0]  new_sbox_val,
  output logic [2:0]  sbox_sel,
  output logic [1:0]  row_sel,
  output logic [3:0]  col_sel,
  output logic        o_cfg_busy,
  output logic        o_done,
  output logic        o_locked
);
  typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [63:0] data, src_data;
  logic [2:0]  sbox, src_sbox;
  logic [1:0]  row, src_row;
  logic [4:0]  cnt;
  logic        rdy, take, issue, lock_n;
  assign take        = i_row_valid & rdy;
  assign o_row_ready = rdy;
  assign o_cfg_busy  = state != IDLE;
  assign o_done      = state == DONE;
  // The first write may issue in the handshake cycle, before the row is captured
  assign src_data = state == IDLE ? i_row_data : data;
  assign src_sbox = state == IDLE ? i_sbox_sel : sbox;
  assign src_row  = state == IDLE ? i_row_sel  : row;
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      IDLE: begin
        state_n = take ? (i_des_busy ? WAIT : WRITE) : IDLE;
        issue   = take & ~i_des_busy;
      end
      WAIT: begin
        state_n = i_des_busy ? WAIT : WRITE;
        issue   = ~i_des_busy;
      end
      WRITE: begin
        state_n = cnt[4] ? DONE : WRITE;
        issue   = ~cnt[4] & ~i_des_busy;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 5'd0;
      rdy          <= 1'b0;
      data         <= 64'd0;
      sbox         <= 3'd0;
      row          <= 2'd0;
      edit_sbox    <= 1'b0;
      new_sbox_val <= 4'd0;
      sbox_sel     <= 3'd0;
      row_sel      <= 2'd0;
      col_sel      <= 4'd0;
    end else begin
      state        <= state_n;
      cnt          <= state == DONE ? 5'd0 : cnt + 5'(issue);
      rdy          <= state_n == IDLE && !lock_n;
      data         <= take ? i_row_data : data;
      sbox         <= take ? i_sbox_sel : sbox;
      row          <= take ? i_row_sel : row;
      edit_sbox    <= issue;
      new_sbox_val <= issue ? src_data[{cnt[3:0], 2'b00} +: 4] : 4'd0;
      sbox_sel     <= issue ? src_sbox : 3'd0;
      row_sel      <= issue ? src_row : 2'd0;
      col_sel      <= issue ? cnt[3:0] : 4'd0;
    end
  end
`ifdef SBOX_CFG_LOCK_EN
  logic lock;
  assign lock_n   = lock | i_lock;
  assign o_locked = lock & (state == IDLE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock <= 1'b0;
    else        lock <= lock_n;
  end
`else
  assign lock_n   = i_lock & 1'b0;
  assign o_locked = 1'b0;
`endif
endmodule

// File: doc/sbox_cfg_ctrl.md
# sbox_cfg_ctrl

Configuration sequencer for the eight editable DES S-boxes. Accepts one full S-box row (16 nibbles) per valid/ready transfer from the host register interface and serialises it into 16 single-entry edit writes on the shared S-box edit bus (edit_sbox, new_sbox_val, sbox_sel, row_sel, col_sel). Holds off edits while the DES round datapath is active, so table contents never change mid-block.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_row_valid  in  1  host presents a row
- o_row_ready  out  1  controller can accept a row
- i_row_data  in  64  row contents; column c = i_row_data[4c+3:4c]
- i_sbox_sel  in  3  target S-box, 0..7
- i_row_sel  in  2  target row, 0..3
- i_des_busy  in  1  DES datapath is using the S-boxes; edits must not fire
- i_lock  in  1  lock request pulse; used only with SBOX_CFG_LOCK_EN
- edit_sbox  out  1  edit strobe to all S-boxes
- new_sbox_val  out  4  entry value
- sbox_sel  out  3  S-box select
- row_sel  out  2  row select
- col_sel  out  4  column select
- o_cfg_busy  out  1  row transfer in progress
- o_done  out  1  one-cycle pulse after the 16th entry is written
- o_locked  out  1  configuration locked

## Operation
- FSM states: IDLE, WAIT, WRITE, DONE.
- IDLE: o_row_ready=1 unless locked. On i_row_valid & o_row_ready, capture i_row_data, i_sbox_sel, i_row_sel, clear column counter to 0. Next state is WAIT if i_des_busy=1, otherwise WRITE.
- WAIT: no edits. Go to WRITE in the first cycle where i_des_busy=0.
- WRITE: per cycle with i_des_busy=0, drive edit_sbox=1, col_sel=counter, new_sbox_val=captured nibble[counter], and sbox_sel/row_sel from the captured values. Then increment the counter.
  - While i_des_busy=1 in WRITE, edit_sbox=0 and the counter holds, so the sequence pauses and resumes where it left off.
  - After column 15 is written, go to DONE.
- DONE: o_done=1 for one cycle, then return to IDLE.
- o_cfg_busy=1 in WAIT, WRITE and DONE. o_row_ready=0 in those states.
- All edit-bus outputs are registered. When edit_sbox=0, new_sbox_val/sbox_sel/row_sel/col_sel are driven 0.
- Values in i_row_data are stored as-is; no range check is needed, since every nibble is legal.
- i_sbox_sel/i_row_sel/i_row_data changes after the handshake have no effect on the row in flight.

## Timing
- Reset (asynchronous, any state): state=IDLE, counter=0, edit_sbox=0, new_sbox_val=0, sbox_sel=0, row_sel=0, col_sel=0, o_cfg_busy=0, o_done=0, o_locked=0. o_row_ready goes to 1 on the first cycle after rst_n deasserts.
- A row in flight at reset is dropped. The S-boxes reset to default tables on the same rst_n.
- With handshake in cycle 0 and i_des_busy=0 throughout:
  - edit_sbox=1 in cycles 1..16, with col_sel 0..15.
  - o_done=1 in cycle 17.
  - o_row_ready=1 again in cycle 18.
- Throughput: one row per 18 cycles when not stalled.
- Each cycle with i_des_busy=1 during WAIT/WRITE adds exactly one cycle to the sequence.
- i_des_busy rising in the same cycle as the handshake: the row is accepted and the FSM enters WAIT.

## Configuration
- SBOX_CFG_LOCK_EN defined:
  - i_lock=1 in any cycle sets a lock flag, which clears only on rst_n.
  - If the lock is set in IDLE, o_locked=1 from the next cycle and o_row_ready stays 0.
  - If the lock is set during WAIT/WRITE/DONE, the current row completes normally. o_locked=1 in the cycle after DONE, and no further rows are accepted.
- SBOX_CFG_LOCK_EN undefined: i_lock is ignored, o_locked is tied to 0, and no lock flag exists.

## Test plan
- Reset, then send row data 64'hFEDCBA9876543210 to sbox 4, row 2 -> cycles 1..16 show sbox_sel=4, row_sel=2, col_sel=c, new_sbox_val=c; o_done in cycle 17. An S-box lookup with i_data={1,c,0} (row 2, column c) returns c.
- Hold i_des_busy=1 for 5 cycles before the handshake and 5 cycles after -> no edit_sbox until busy falls; first edit in cycle 6, o_done in cycle 22.
- Raise i_des_busy for 3 cycles after column 7 is written -> edit_sbox=0 and col_sel holds for 3 cycles; resumes at column 8; o_done is delayed by 3 cycles.
- Present two back-to-back rows with i_row_valid held high -> second handshake in cycle 18; no overlap of edit strobes; all 32 entries correct.
- Assert rst_n=0 at column 9 -> all outputs 0 immediately; after release, o_row_ready=1 and the S-box holds its default table.
- With SBOX_CFG_LOCK_EN: pulse i_lock at column 3 -> the row finishes, o_locked=1 after DONE, o_row_ready stays 0, and a new i_row_valid produces no edits. Without the macro, the same stimulus leaves o_locked=0 and the next row is accepted.
